// File: rtl/c64_bus_arbiter.sv
// Shares the single-port system RAM between the CPU and the video fetch unit.
// Video owns phase 0 (or every cycle while stealing); the CPU owns phase 1.
module c64_bus_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BA_LEAD = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_ce,
  output logic              cpu_rdy,
  input  logic              vid_req,
  input  logic              vid_steal,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] ram_ab,
  output logic [DATA_W-1:0] ram_do,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_di
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_BA_WAIT, ST_STEAL} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_VID} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              phase_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_di_q;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              vid_valid_q;
  logic              vid_slot_c, cpu_slot_c, vid_ack_c;

  // Slot decode; vid_ack is masked by reset so the bus goes quiet without a clock.
  always_comb begin
    vid_slot_c = (state_q == ST_STEAL) || !phase_q;
    cpu_slot_c = (state_q != ST_STEAL) && phase_q;
    vid_ack_c  = vid_slot_c && vid_req && reset;
  end

  assign cpu_ce    = cpu_slot_c;
  assign vid_ack   = vid_ack_c;
  assign ram_ab    = vid_ack_c ? vid_addr : cpu_ab;
  assign ram_do    = cpu_do;
  assign ram_we    = cpu_slot_c && cpu_we;
  assign vid_data  = ram_di;
  assign cpu_di    = cpu_di_q;
  assign cpu_rdy   = cpu_rdy_q;
  assign vid_valid = vid_valid_q;

  // Slot owner and steal sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = OWN_NONE;

    if (vid_ack_c) begin
      owner_d = OWN_VID;
    end else if (cpu_slot_c && !cpu_we) begin
      owner_d = OWN_CPU_RD;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (vid_steal) begin
          state_d = ST_BA_WAIT;
          cnt_d   = '0;
        end
      end
      ST_BA_WAIT: begin
        if (!vid_steal) begin
          state_d = ST_IDLE;
        end else if (cpu_slot_c) begin
          if (cnt_q == CNT_W'(BA_LEAD - 1)) begin
            state_d = ST_STEAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_STEAL: begin
        // Release only on phase 1 so the next cycle is a video slot.
        if (!vid_steal && phase_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_NONE;
      cpu_di_q    <= '0;
      cpu_rdy_q   <= 1'b1;
      vid_valid_q <= 1'b0;
    end else begin
      phase_q     <= ~phase_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      cpu_rdy_q   <= cpu_rdy_d;
      vid_valid_q <= (owner_d == OWN_VID);
      if (owner_q == OWN_CPU_RD) begin
        cpu_di_q <= ram_di;
      end
    end
  end

endmodule
